aligner_lock_fsm: RTL and testbench
===================================

Name: aligner_lock_fsm

Overview:
- Parametrised successor to the gearbox block aligner.
- Finds the 2-bit sync-header position within the gearbox buffer using a rotating priority search, then confirms it over LOCK_CNT consecutive blocks.
- Holds lock with windowed error hysteresis and emits the aligned block.
- Sits between the gearbox and the descrambler/frame decoder.

Parameters:
- BLOCK_W, 66, block width in bits including the 2-bit sync header.
- SEARCH_W, 128, number of candidate offsets (0..SEARCH_W-1).
- BUF_W, 194, gearbox buffer width; must be at least SEARCH_W+BLOCK_W.
- LOCK_CNT, 32, consecutive good headers required to declare lock; must be at least 2.
- WINDOW, 64, monitoring window length in blocks while locked.
- UNLOCK_ERR, 16, bad headers within one window that force loss of lock.
- CNT_W, 6, width of the saturating statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- gbox_buffer_i  in  BUF_W  gearbox buffer; sampled only when buffer_dv_i=1.
- buffer_dv_i  in  1  one-cycle strobe marking a new buffer word.
- restart_i  in  1  forces HUNT from the current offset+1.
- block_offset_o  out  clog2(SEARCH_W)  current candidate/locked offset.
- locked_o  out  1  high in LOCKED.
- block_o  out  BLOCK_W  aligned block, gbox_buffer_i[offset +: BLOCK_W].
- block_dv_o  out  1  block_o valid.
- hdr_err_o  out  1  qualifies block_dv_o; the header of block_o was invalid.
- fail_cnt_o  out  CNT_W  saturating count of CHECK failures.
- loss_cnt_o  out  CNT_W  saturating count of lock losses.

Behaviour:
- Header validity: candidate k is valid iff gbox_buffer_i[k+1] != gbox_buffer_i[k] (patterns 01 or 10).
- Reset (rst_i=1 at a clock edge):
  - state=HUNT;
  - offset, good_cnt, win_cnt, bad_cnt, fail_cnt_o, loss_cnt_o = 0;
  - locked_o, block_dv_o, hdr_err_o = 0; block_o = 0.
  - Reset mid-operation discards all progress.
- All state updates occur only on cycles with buffer_dv_i=1. Other cycles hold state; block_dv_o=0.
- HUNT, on dv:
  - Search k = offset, offset+1, …, wrapping mod SEARCH_W, for the first valid candidate.
  - Found: offset<=k, good_cnt<=1, go to CHECK.
  - None found: offset unchanged, stay in HUNT.
- CHECK, on dv:
  - Header at offset valid: good_cnt+1. When good_cnt+1 reaches LOCK_CNT, go to LOCKED; locked_o=1 from the next cycle; win_cnt and bad_cnt cleared.
  - Header invalid: offset<=(offset+1) mod SEARCH_W, good_cnt<=0, fail_cnt_o+1 (saturating), go to HUNT.
- LOCKED, on dv:
  - win_cnt+1; bad_cnt+1 if the header is invalid.
  - If bad_cnt+1 reaches UNLOCK_ERR: go to HUNT, offset<=(offset+1) mod SEARCH_W, locked_o<=0, loss_cnt_o+1 (saturating).
  - Otherwise, if win_cnt+1 reaches WINDOW: clear win_cnt and bad_cnt.
  - Error on the last block of a window: the unlock check precedes the window clear.
- Output latency: one cycle.
  - A dv accepted while state was LOCKED (pre-update) produces block_dv_o=1 on the next cycle.
  - block_o = buffer[offset +: BLOCK_W] using the pre-update offset.
  - hdr_err_o = that block's header invalid.
  - The block that causes unlock is still output, with hdr_err_o=1.
- restart_i=1 at a clock edge, any state:
  - HUNT, offset+1 mod SEARCH_W, counters good/win/bad cleared, locked_o=0.
  - Not counted in fail_cnt_o or loss_cnt_o.
  - restart_i beats buffer_dv_i in the same cycle; that dv is dropped.
  - rst_i beats restart_i.
- Offset wrap: SEARCH_W-1 increments to 0.
- Statistics counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset, then dv every 8 cycles with only buffer bit 40=1 (candidates 39, 40) → HUNT picks offset 39; after 32 dvs locked_o=1, block_offset_o=39; the 33rd dv gives block_dv_o=1 one cycle later, block_o=buffer[104:39], hdr_err_o=0.
- After lock, 15 all-zero buffers inside one window → locked_o stays 1, 15 hdr_err_o pulses; a 16th in the same window → HUNT, offset 40, loss_cnt_o=1.
- 15 bad headers per window across 3 windows of 64 → never unlocks; loss_cnt_o=0.
- In CHECK at good_cnt=10, one bad header → HUNT, offset 40, fail_cnt_o=1; the next dv with only bit 40=1 → CHECK at offset 40.
- Valid header only at k=5 while offset=120 → rotating search wraps and selects 5; repeated CHECK failures saturate fail_cnt_o at 63.
- restart_i asserted together with dv while LOCKED at 39 → dv dropped, state HUNT, offset 40, no counter change; rst_i asserted mid-CHECK → all outputs 0 the next cycle.

Source files
------------

// File: rtl/aligner_lock_fsm_if.sv
// Gearbox-side bus of the block aligner: buffer word, strobe and restart in;
// aligned block, lock status and statistics out.
interface aligner_lock_fsm_if #(
    parameter int BUF_W   = 194,
    parameter int BLOCK_W = 66,
    parameter int OFF_W   = 7,
    parameter int CNT_W   = 6
);
    logic [BUF_W-1:0]   gbox_buffer_i;
    logic               buffer_dv_i;
    logic               restart_i;
    logic [OFF_W-1:0]   block_offset_o;
    logic               locked_o;
    logic [BLOCK_W-1:0] block_o;
    logic               block_dv_o;
    logic               hdr_err_o;
    logic [CNT_W-1:0]   fail_cnt_o;
    logic [CNT_W-1:0]   loss_cnt_o;

    modport master (
        output gbox_buffer_i, buffer_dv_i, restart_i,
        input  block_offset_o, locked_o, block_o, block_dv_o, hdr_err_o,
               fail_cnt_o, loss_cnt_o
    );

    modport slave (
        input  gbox_buffer_i, buffer_dv_i, restart_i,
        output block_offset_o, locked_o, block_o, block_dv_o, hdr_err_o,
               fail_cnt_o, loss_cnt_o
    );
endinterface

// File: rtl/aligner_lock_fsm.sv
// Sync-header block aligner: rotating search for a 01/10 header, LOCK_CNT-block
// confirmation, then windowed error hysteresis while emitting aligned blocks.
module aligner_lock_fsm #(
    parameter int BLOCK_W    = 66,
    parameter int SEARCH_W   = 128,
    parameter int BUF_W      = 194,
    parameter int LOCK_CNT   = 32,
    parameter int WINDOW     = 64,
    parameter int UNLOCK_ERR = 16,
    parameter int CNT_W      = 6
) (
    input logic               clk_i,
    input logic               rst_i,
    aligner_lock_fsm_if.slave bus
);
    localparam int OFF_W  = $clog2(SEARCH_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SEARCH_W - 1);
    localparam logic [OFF_W:0]   SW_EXT   = (OFF_W + 1)'(SEARCH_W);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t             state;
    logic [OFF_W-1:0]   offset;
    logic [GOOD_W-1:0]  good_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [BAD_W-1:0]   bad_cnt;
    logic               locked;
    logic [BLOCK_W-1:0] block_q;
    logic               block_dv;
    logic               hdr_err;
    logic [CNT_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]   loss_cnt;

    logic [SEARCH_W-1:0]   cand_ok;
    logic [SEARCH_W-1:0]   cand_rot;
    logic [2*SEARCH_W-1:0] cand_dbl;
    logic                  hit_found;
    logic [OFF_W-1:0]      hit_rel;
    logic [OFF_W:0]        hit_sum;
    logic [OFF_W:0]        hit_wrap;
    logic [OFF_W-1:0]      hit_off;
    logic [OFF_W-1:0]      off_inc;
    logic                  hdr_ok;
    logic [GOOD_W-1:0]     good_nxt;
    logic [WIN_W-1:0]      win_nxt;
    logic [BAD_W-1:0]      bad_nxt;

    always_comb begin
        cand_ok = '0;
        for (int k = 0; k < SEARCH_W; k++)
            cand_ok[k] = bus.gbox_buffer_i[k+1] ^ bus.gbox_buffer_i[k];
    end

    // Rotate so the current offset sits at bit 0; the lowest set bit is then the
    // first valid candidate in wrap-around search order.
    assign cand_dbl = {cand_ok, cand_ok} >> offset;
    assign cand_rot = cand_dbl[SEARCH_W-1:0];

    always_comb begin
        hit_found = 1'b0;
        hit_rel   = '0;
        for (int i = SEARCH_W - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                hit_found = 1'b1;
                hit_rel   = OFF_W'(i);
            end
        end
    end

    assign hit_sum  = {1'b0, offset} + {1'b0, hit_rel};
    assign hit_wrap = hit_sum - SW_EXT;
    assign hit_off  = (hit_sum >= SW_EXT) ? hit_wrap[OFF_W-1:0] : hit_sum[OFF_W-1:0];
    assign off_inc  = (offset == OFF_LAST) ? '0 : offset + 1'b1;
    assign hdr_ok   = cand_ok[offset];
    assign good_nxt = good_cnt + 1'b1;
    assign win_nxt  = win_cnt + 1'b1;
    assign bad_nxt  = bad_cnt + BAD_W'(!hdr_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= HUNT;
            offset   <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
            block_q  <= '0;
            block_dv <= 1'b0;
            hdr_err  <= 1'b0;
            fail_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            block_dv <= 1'b0;
            hdr_err  <= 1'b0;
            if (bus.restart_i) begin
                state    <= HUNT;
                offset   <= off_inc;
                good_cnt <= '0;
                win_cnt  <= '0;
                bad_cnt  <= '0;
                locked   <= 1'b0;
            end else if (bus.buffer_dv_i) begin
                if (state == LOCKED) begin
                    block_dv <= 1'b1;
                    block_q  <= bus.gbox_buffer_i[offset +: BLOCK_W];
                    hdr_err  <= !hdr_ok;
                end
                case (state)
                    HUNT: begin
                        if (hit_found) begin
                            offset   <= hit_off;
                            good_cnt <= GOOD_W'(1);
                            state    <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (hdr_ok) begin
                            good_cnt <= good_nxt;
                            if (good_nxt == GOOD_W'(LOCK_CNT)) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_cnt <= '0;
                                bad_cnt <= '0;
                            end
                        end else begin
                            offset   <= off_inc;
                            good_cnt <= '0;
                            state    <= HUNT;
                            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Unlock takes precedence over the end-of-window clear.
                        if (bad_nxt == BAD_W'(UNLOCK_ERR)) begin
                            state    <= HUNT;
                            offset   <= off_inc;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            bad_cnt  <= '0;
                            if (loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
                        end else if (win_nxt == WIN_W'(WINDOW)) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_nxt;
                            bad_cnt <= bad_nxt;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.block_offset_o = offset;
    assign bus.locked_o       = locked;
    assign bus.block_o        = block_q;
    assign bus.block_dv_o     = block_dv;
    assign bus.hdr_err_o      = hdr_err;
    assign bus.fail_cnt_o     = fail_cnt;
    assign bus.loss_cnt_o     = loss_cnt;
endmodule

// File: tb/tb_aligner_lock_fsm.sv
// Directed bench for the block aligner: vector table plus hand-written
// sequences for window hysteresis, search wrap and counter saturation.
module tb_aligner_lock_fsm;
    localparam int BUF_W = 194;
    localparam int BLK_W = 66;

    localparam int P_ZERO  = 0;
    localparam int P_BIT40 = 1;
    localparam int P_BIT6  = 2;
    localparam int P_ALT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    aligner_lock_fsm_if #(.BUF_W(BUF_W), .BLOCK_W(BLK_W), .OFF_W(7), .CNT_W(6)) bus ();

    aligner_lock_fsm dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic r;
        logic rs;
        logic dv;
        int   pat;
        int   rep;
        logic e_lock;
        int   e_off;
        logic e_dv;
        logic e_err;
        int   e_fail;
        int   e_loss;
    } vec_t;

    vec_t vt[16];

    function automatic logic [BUF_W-1:0] pat_buf(int p);
        logic [BUF_W-1:0] b;
        b = '0;
        case (p)
            P_BIT40: b[40] = 1'b1;
            P_BIT6:  b[6]  = 1'b1;
            P_ALT:   for (int i = 0; i < BUF_W; i++) b[i] = i[0];
            default: b = '0;
        endcase
        return b;
    endfunction

    task automatic chk(string nm, logic [BLK_W-1:0] got, logic [BLK_W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_all(string tag, logic lk, int off, logic dv, logic er, int fl, int ls);
        chk({tag, ".locked"}, BLK_W'(bus.locked_o), BLK_W'(lk));
        chk({tag, ".offset"}, BLK_W'(bus.block_offset_o), BLK_W'(off));
        chk({tag, ".block_dv"}, BLK_W'(bus.block_dv_o), BLK_W'(dv));
        chk({tag, ".hdr_err"}, BLK_W'(bus.hdr_err_o), BLK_W'(er));
        chk({tag, ".fail_cnt"}, BLK_W'(bus.fail_cnt_o), BLK_W'(fl));
        chk({tag, ".loss_cnt"}, BLK_W'(bus.loss_cnt_o), BLK_W'(ls));
    endtask

    task automatic step(logic r, logic rs, logic dv, logic [BUF_W-1:0] b);
        rst = r;
        bus.restart_i = rs;
        bus.buffer_dv_i = dv;
        bus.gbox_buffer_i = b;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.restart_i = 1'b0;
        bus.buffer_dv_i = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [BUF_W-1:0] rich;
        logic [BUF_W-1:0] shifted;
        int pulses;

        //        r  rs dv pat      rep lock off dv err fail loss
        vt[0]  = '{1, 0, 0, P_ZERO,  1,  0,   0,  0, 0,  0,   0};
        vt[1]  = '{0, 0, 1, P_BIT40, 1,  0,   39, 0, 0,  0,   0};
        vt[2]  = '{0, 0, 1, P_BIT40, 30, 0,   39, 0, 0,  0,   0};
        vt[3]  = '{0, 0, 1, P_BIT40, 1,  1,   39, 0, 0,  0,   0};
        vt[4]  = '{0, 0, 1, P_BIT40, 1,  1,   39, 1, 0,  0,   0};
        vt[5]  = '{0, 0, 0, P_ZERO,  1,  1,   39, 0, 0,  0,   0};
        vt[6]  = '{0, 0, 1, P_ZERO,  15, 1,   39, 1, 1,  0,   0};
        vt[7]  = '{0, 0, 1, P_ZERO,  1,  0,   40, 1, 1,  0,   1};
        vt[8]  = '{0, 0, 1, P_BIT40, 1,  0,   40, 0, 0,  0,   1};
        vt[9]  = '{0, 0, 1, P_BIT40, 31, 1,   40, 0, 0,  0,   1};
        vt[10] = '{0, 1, 1, P_ZERO,  1,  0,   41, 0, 0,  0,   1};
        vt[11] = '{0, 0, 1, P_BIT40, 1,  0,   39, 0, 0,  0,   1};
        vt[12] = '{0, 0, 1, P_BIT40, 9,  0,   39, 0, 0,  0,   1};
        vt[13] = '{0, 0, 1, P_ZERO,  1,  0,   40, 0, 0,  1,   1};
        vt[14] = '{0, 0, 1, P_BIT40, 1,  0,   40, 0, 0,  1,   1};
        vt[15] = '{1, 0, 0, P_ZERO,  1,  0,   0,  0, 0,  0,   0};

        bus.gbox_buffer_i = '0;
        bus.buffer_dv_i = 1'b0;
        bus.restart_i = 1'b0;
        idle(2);

        // Table: each row repeated rep times, dv every 8 cycles, checked after the last.
        for (int v = 0; v < 16; v++) begin
            for (int r = 0; r < vt[v].rep; r++) begin
                step(vt[v].r, vt[v].rs, vt[v].dv, pat_buf(vt[v].pat));
                if (r == vt[v].rep - 1)
                    chk_all($sformatf("vec%0d", v), vt[v].e_lock, vt[v].e_off, vt[v].e_dv,
                            vt[v].e_err, vt[v].e_fail, vt[v].e_loss);
                idle(7);
            end
        end

        // Aligned block data, then reset clears it.
        step(1, 0, 0, '0);
        for (int i = 0; i < 32; i++) step(0, 0, 1, pat_buf(P_BIT40));
        chk("lock1.locked", BLK_W'(bus.locked_o), BLK_W'(1));
        rich = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rich[40] = 1'b1;
        rich[39] = 1'b0;
        step(0, 0, 1, rich);
        shifted = rich >> 39;
        chk("rich.block", bus.block_o, shifted[BLK_W-1:0]);
        chk("rich.dv", BLK_W'(bus.block_dv_o), BLK_W'(1));
        chk("rich.err", BLK_W'(bus.hdr_err_o), BLK_W'(0));
        step(0, 0, 1, pat_buf(P_BIT40));
        chk("bit40.block", bus.block_o, BLK_W'(2));
        step(1, 0, 0, '0);
        chk("rst.block", bus.block_o, '0);
        chk_all("rst2", 0, 0, 0, 0, 0, 0);

        // Three windows of 15 bad + 49 good never unlock.
        for (int i = 0; i < 32; i++) step(0, 0, 1, pat_buf(P_BIT40));
        pulses = 0;
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 64; i++) begin
                step(0, 0, 1, pat_buf(i < 15 ? P_ZERO : P_BIT40));
                if (bus.block_dv_o && bus.hdr_err_o) pulses++;
            end
        chk("win3.pulses", BLK_W'(pulses), BLK_W'(45));
        chk_all("win3", 1, 39, 1, 0, 0, 0);

        // 16th error lands on the last block of a window: unlock wins.
        for (int i = 0; i < 48; i++) step(0, 0, 1, pat_buf(P_BIT40));
        for (int i = 0; i < 15; i++) step(0, 0, 1, pat_buf(P_ZERO));
        chk("edge.locked63", BLK_W'(bus.locked_o), BLK_W'(1));
        step(0, 0, 1, pat_buf(P_ZERO));
        chk_all("edge64", 0, 40, 1, 1, 0, 1);

        // Offset wrap under restart, then rotating search wraps to candidate 5.
        step(1, 0, 0, '0);
        for (int i = 0; i < 127; i++) step(0, 1, 0, '0);
        chk("wrap.off127", BLK_W'(bus.block_offset_o), BLK_W'(127));
        step(0, 1, 0, '0);
        chk("wrap.off0", BLK_W'(bus.block_offset_o), BLK_W'(0));
        for (int i = 0; i < 120; i++) step(0, 1, 0, '0);
        chk_all("wrap120", 0, 120, 0, 0, 0, 0);
        step(0, 0, 1, pat_buf(P_BIT6));
        chk_all("search5", 0, 5, 0, 0, 0, 0);

        // Repeated CHECK failures saturate fail_cnt at 63.
        for (int i = 0; i < 70; i++) begin
            step(0, 0, 1, pat_buf(P_ZERO));
            if (i == 0)  chk("sat.fail1", BLK_W'(bus.fail_cnt_o), BLK_W'(1));
            if (i == 62) chk("sat.fail63", BLK_W'(bus.fail_cnt_o), BLK_W'(63));
            step(0, 0, 1, pat_buf(P_ALT));
        end
        chk_all("sat70", 0, 75, 0, 0, 63, 0);

        // restart with dv while locked at 39.
        step(1, 0, 0, '0);
        for (int i = 0; i < 32; i++) step(0, 0, 1, pat_buf(P_BIT40));
        step(0, 1, 1, pat_buf(P_BIT40));
        chk_all("rstart", 0, 40, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
